// File: rtl/fetch_ifid_stage.sv
// fetch_ifid_stage: IF stage and IF/ID pipeline register.
// The stage owns the PC and fetches from instruction memory with a req/ready handshake.
// - stall_pipeline holds the stage.
// - flush_pipeline squashes the IF/ID contents and redirects the PC to branch_target.
// - A one-entry skid buffer catches a word that returns while the pipeline is stalled.
// - The DRAIN state waits out the fetch that was in flight when a flush arrived.
// Ports:
//   clk, reset                      clock and synchronous active-high reset
//   stall_pipeline, flush_pipeline  hazard-unit controls
//   branch_target                   redirect address (low two bits are ignored)
//   imem_req/imem_addr/imem_ready/imem_rdata  instruction memory handshake
//   ifid_instr/ifid_pc/ifid_valid   IF/ID register presented to the ID stage
//   fetch_state                     debug: 00 FETCH, 01 FULL, 10 DRAIN
module fetch_ifid_stage #(
  parameter int unsigned        ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter logic [31:0]        NOP_INSTR = 32'hE1A0_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_pipeline,
  input  logic              flush_pipeline,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       ifid_instr,
  output logic [ADDR_W-1:0] ifid_pc,
  output logic              ifid_valid,
  output logic [1:0]        fetch_state
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_FULL  = 2'b01,
    ST_DRAIN = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] redirect_q, redirect_d;
  logic [31:0]       skid_instr_q, skid_instr_d;
  logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
  logic [31:0]       ifid_instr_d;
  logic [ADDR_W-1:0] ifid_pc_d;
  logic              ifid_valid_d;
  logic [ADDR_W-1:0] target_aligned;
  logic [ADDR_W-1:0] pc_inc;
  logic              xfer;

  // Handshake and address generation. No request is made from FULL or during reset.
  assign imem_req       = !reset && (state_q != ST_FULL);
  assign imem_addr      = pc_q;
  assign fetch_state    = state_q;
  assign xfer           = imem_req && imem_ready;
  assign target_aligned = branch_target & ~ADDR_W'(3);
  assign pc_inc         = pc_q + ADDR_W'(4);

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC;
      redirect_q   <= '0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      ifid_instr   <= NOP_INSTR;
      ifid_pc      <= '0;
      ifid_valid   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      redirect_q   <= redirect_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      ifid_instr   <= ifid_instr_d;
      ifid_pc      <= ifid_pc_d;
      ifid_valid   <= ifid_valid_d;
    end
  end

  // Next-state logic. Flush takes priority over stall in every state.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    redirect_d   = redirect_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    ifid_instr_d = ifid_instr;
    ifid_pc_d    = ifid_pc;
    ifid_valid_d = ifid_valid;

    unique case (state_q)
      ST_FETCH: begin
        if (flush_pipeline) begin
          ifid_instr_d = NOP_INSTR;
          ifid_valid_d = 1'b0;
          if (xfer) begin
            pc_d = target_aligned;
          end else begin
            // The current request is still outstanding; retire it before redirecting.
            redirect_d = target_aligned;
            state_d    = ST_DRAIN;
          end
        end else if (stall_pipeline) begin
          if (xfer) begin
            skid_instr_d = imem_rdata;
            skid_pc_d    = pc_q;
            pc_d         = pc_inc;
            state_d      = ST_FULL;
          end
        end else if (xfer) begin
          ifid_instr_d = imem_rdata;
          ifid_pc_d    = pc_q;
          ifid_valid_d = 1'b1;
          pc_d         = pc_inc;
        end else begin
          ifid_instr_d = NOP_INSTR;
          ifid_valid_d = 1'b0;
        end
      end

      ST_FULL: begin
        if (flush_pipeline) begin
          pc_d         = target_aligned;
          ifid_instr_d = NOP_INSTR;
          ifid_valid_d = 1'b0;
          state_d      = ST_FETCH;
        end else if (!stall_pipeline) begin
          ifid_instr_d = skid_instr_q;
          ifid_pc_d    = skid_pc_q;
          ifid_valid_d = 1'b1;
          state_d      = ST_FETCH;
        end
      end

      ST_DRAIN: begin
        // The returned word belongs to the squashed path, so it is never used.
        ifid_instr_d = NOP_INSTR;
        ifid_valid_d = 1'b0;
        if (xfer) begin
          pc_d    = flush_pipeline ? target_aligned : redirect_q;
          state_d = ST_FETCH;
        end else if (flush_pipeline) begin
          redirect_d = target_aligned;
        end
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

endmodule
